// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: instruction port, data port and the shared memory handshake.
// The arbiter takes the slave view; the requesters and memory model take the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one backing memory between the I-fetch refill port and the D load/store port.
// D wins ties unless it won the previous grant; a watchdog aborts stalled transactions.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_is_d_q, owner_is_d_d;
    logic              last_is_d_q, last_is_d_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              i_err_q, i_err_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;
    logic              pick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_is_d_q <= 1'b0;
            last_is_d_q  <= 1'b0;
            wd_q         <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            i_err_q      <= 1'b0;
            d_rdata_q    <= '0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_is_d_q <= owner_is_d_d;
            last_is_d_q  <= last_is_d_d;
            wd_q         <= wd_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            i_err_q      <= i_err_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_is_d_d = owner_is_d_q;
        last_is_d_d  = last_is_d_q;
        wd_d         = wd_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        i_err_d      = i_err_q;
        d_rdata_d    = d_rdata_q;
        d_err_d      = d_err_q;
        // D takes a tie only when it did not win the previous grant
        pick_d       = bus.d_req && (!bus.i_req || !last_is_d_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    owner_is_d_d = pick_d;
                    last_is_d_d  = pick_d;
                    wd_d         = '0;
                    mem_we_d     = pick_d && bus.d_we;
                    mem_addr_d   = pick_d ? bus.d_addr : bus.i_addr;
                    mem_wdata_d  = pick_d ? bus.d_wdata : '0;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    state_d = ST_DONE;
                    if (owner_is_d_q) begin
                        if (!mem_we_q) d_rdata_d = bus.mem_rdata;
                        d_err_d = 1'b0;
                    end else begin
                        i_rdata_d = bus.mem_rdata;
                        i_err_d   = 1'b0;
                    end
                end else if (wd_q == WD_LAST) begin
                    // watchdog expiry: complete with zero data and the error flag
                    state_d = ST_DONE;
                    if (owner_is_d_q) begin
                        d_rdata_d = '0;
                        d_err_d   = 1'b1;
                    end else begin
                        i_rdata_d = '0;
                        i_err_d   = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_req   = (state_q == ST_BUSY);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_ack     = (state_q == ST_DONE) && !owner_is_d_q;
    assign bus.d_ack     = (state_q == ST_DONE) && owner_is_d_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_err     = i_err_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts the grant winner,
// memory-side beats, completion cycle and per-port rdata/err, and compares against the DUT.
module tb_mem_arbiter;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_trans  = 0;

    // reference model state
    bit          exp_last_d;
    logic [31:0] m_i_rdata, m_d_rdata;
    bit          m_i_err, m_d_err;
    bit          seen_ack_d;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},   64'(bus.mem_req),   64'd0);
        check({tag, "_mem_we"},    64'(bus.mem_we),    64'd0);
        check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
        check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check({tag, "_i_ack"},     64'(bus.i_ack),     64'd0);
        check({tag, "_d_ack"},     64'(bus.d_ack),     64'd0);
        check({tag, "_i_err"},     64'(bus.i_err),     64'd0);
        check({tag, "_d_err"},     64'(bus.d_err),     64'd0);
        check({tag, "_i_rdata"},   64'(bus.i_rdata),   64'd0);
        check({tag, "_d_rdata"},   64'(bus.d_rdata),   64'd0);
        check({tag, "_busy"},      64'(bus.busy),      64'd0);
    endtask

    // Precondition: DUT idle, at least one request held. Memory answers in BUSY cycle lat
    // (lat > TIMEOUT means it never answers).
    task automatic run_txn(input int lat, input logic [31:0] rd_val);
        bit          own_d, is_wr, got;
        logic [31:0] e_addr, e_wdata;
        int          n_req;
        own_d      = bus.d_req && (!bus.i_req || !exp_last_d);
        is_wr      = own_d && bus.d_we;
        e_addr     = own_d ? bus.d_addr : bus.i_addr;
        e_wdata    = bus.d_wdata;
        exp_last_d = own_d;
        n_trans++;

        tick();
        check("grant_busy",   64'(bus.busy),   64'd1);
        check("grant_mem_we", 64'(bus.mem_we), 64'(is_wr));
        // inputs wander while busy; the latched request must not follow them
        bus.i_addr  = $urandom;
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;

        got   = 0;
        n_req = 0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            if (bus.mem_req) n_req++;
            check("busy_mem_addr", 64'(bus.mem_addr), 64'(e_addr));
            if (is_wr) check("busy_mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
            if (c == lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rd_val;
                got = 1;
            end
            tick();
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            if (got) break;
        end
        check("mem_req_cycles", 64'(n_req), got ? 64'(lat) : 64'(TIMEOUT));

        if (!got) begin
            if (own_d) begin m_d_rdata = '0; m_d_err = 1; end
            else       begin m_i_rdata = '0; m_i_err = 1; end
        end else if (own_d) begin
            if (!is_wr) m_d_rdata = rd_val;
            m_d_err = 0;
        end else begin
            m_i_rdata = rd_val;
            m_i_err   = 0;
        end

        seen_ack_d = bus.d_ack;
        check("done_mem_req", 64'(bus.mem_req), 64'd0);
        check("done_busy",    64'(bus.busy),    64'd1);
        check("done_i_ack",   64'(bus.i_ack),   64'(!own_d));
        check("done_d_ack",   64'(bus.d_ack),   64'(own_d));
        check("done_i_rdata", 64'(bus.i_rdata), 64'(m_i_rdata));
        check("done_i_err",   64'(bus.i_err),   64'(m_i_err));
        check("done_d_rdata", 64'(bus.d_rdata), 64'(m_d_rdata));
        check("done_d_err",   64'(bus.d_err),   64'(m_d_err));
        $display("txn %0d port=%s we=%0d addr=%08h lat=%0d timeout=%0d i_rdata=%08h d_rdata=%08h",
                 n_trans, own_d ? "D" : "I", is_wr, e_addr, lat, !got, bus.i_rdata, bus.d_rdata);

        tick();
        if (own_d) bus.d_req = 1'b0;
        else       bus.i_req = 1'b0;
        check("idle_busy",    64'(bus.busy),    64'd0);
        check("idle_mem_req", 64'(bus.mem_req), 64'd0);
        check("idle_i_ack",   64'(bus.i_ack),   64'd0);
        check("idle_d_ack",   64'(bus.d_ack),   64'd0);
        check("idle_i_rdata", 64'(bus.i_rdata), 64'(m_i_rdata));
        check("idle_d_rdata", 64'(bus.d_rdata), 64'(m_d_rdata));
    endtask

    initial begin
        bit order [4];
        int r;
        order = '{1'b1, 1'b0, 1'b1, 1'b0};
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
        exp_last_d = 0; m_i_rdata = 0; m_d_rdata = 0; m_i_err = 0; m_d_err = 0;

        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        tick();
        bus.mem_ready = 1'b0;
        check("idle_ready_i_ack", 64'(bus.i_ack), 64'd0);
        check("idle_ready_d_ack", 64'(bus.d_ack), 64'd0);
        check("idle_ready_busy",  64'(bus.busy),  64'd0);

        // D write, 3-cycle memory
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'h12345678;
        run_txn(3, 32'h55AA55AA);

        // I read, memory ready in first BUSY cycle
        bus.i_req = 1; bus.i_addr = 32'h40;
        run_txn(1, 32'hDEADBEEF);

        // contention: both held high, expect D, I, D, I
        bus.d_we = 0;
        bus.i_req = 1; bus.d_req = 1;
        for (int k = 0; k < 4; k++) begin
            bus.i_addr = $urandom; bus.d_addr = $urandom;
            run_txn(int'($urandom_range(1, 4)), $urandom);
            check("contention_order", 64'(seen_ack_d), 64'(order[k]));
            bus.i_req = 1; bus.d_req = 1;
        end
        // drain the leftover I request so the timeout test starts clean
        bus.d_req = 0;
        run_txn(2, $urandom);
        bus.i_req = 0;

        // timeout on D read, then a good read clears err
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        run_txn(TIMEOUT + 5, $urandom);
        bus.d_req = 1; bus.d_addr = 32'h204;
        run_txn(2, 32'h0BADC0DE);

        // reset in the second BUSY cycle of an I read
        bus.i_req = 1; bus.i_addr = 32'h80;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_busy_i_ack",   64'(bus.i_ack),   64'd0);
        check("rst_busy_d_ack",   64'(bus.d_ack),   64'd0);
        check("rst_busy_busy",    64'(bus.busy),    64'd0);
        check("rst_busy_i_rdata", 64'(bus.i_rdata), 64'd0);
        exp_last_d = 0; m_i_rdata = 0; m_d_rdata = 0; m_i_err = 0; m_d_err = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
        run_txn(2, $urandom);
        check("rst_priority_d", 64'(seen_ack_d), 64'd1);
        run_txn(1, $urandom);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            if (!bus.i_req && !bus.d_req) begin
                r = int'($urandom_range(1, 3));
                bus.i_req = r[0];
                bus.d_req = r[1];
            end else if ($urandom_range(0, 1) == 1) begin
                bus.i_req = 1; bus.d_req = 1;
            end
            bus.i_addr  = $urandom;
            bus.d_addr  = $urandom;
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_wdata = $urandom;
            run_txn(int'($urandom_range(1, TIMEOUT + 2)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single backing data memory between the instruction-side fetch path (L1 refill) and the data-side load/store path of the MIPS CPU. It sits between `l1_cache`/fetch logic and `dm`, serialises requests with D-priority and anti-starvation fairness, and drives a single req/ready memory handshake. A watchdog aborts transactions that the memory never completes.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 15, max cycles in BUSY without `mem_ready` before abort (≥1)

- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `i_req` in 1: instruction-side read request, held until `i_ack`
- `i_addr` in ADDR_W: instruction read address
- `i_ack` out 1: one-cycle completion pulse, I port
- `i_rdata` out DATA_W: I read data, valid with `i_ack`, held until next `i_ack`
- `i_err` out 1: timeout flag, valid with `i_ack`
- `d_req` in 1: data-side request, held until `d_ack`
- `d_we` in 1: 1 = write, 0 = read
- `d_addr` in ADDR_W: data address
- `d_wdata` in DATA_W: write data
- `d_ack` out 1: one-cycle completion pulse, D port
- `d_rdata` out DATA_W: D read data, valid with `d_ack` on reads
- `d_err` out 1: timeout flag, valid with `d_ack`
- `mem_req` out 1: memory request, held through BUSY
- `mem_we` out 1: memory write enable
- `mem_addr` out ADDR_W: memory address
- `mem_wdata` out DATA_W: memory write data
- `mem_ready` in 1: memory completion, sampled only in BUSY
- `mem_rdata` in DATA_W: memory read data, valid with `mem_ready`
- `busy` out 1: state != IDLE

## Operation
- States: IDLE, BUSY, DONE. Register `last_grant` (I or D), `owner` (I or D), watchdog counter `wd` (width ≥ clog2(TIMEOUT+1)).
- IDLE: sample `i_req`/`d_req`. Only one high -> grant it. Both high -> grant D unless `last_grant`==D, then grant I. On grant: latch addr/we/wdata into `mem_*` registers (I grant forces `mem_we`=0), set `owner`, `last_grant`=owner, `wd`=0, go BUSY. None high -> stay.
- BUSY: `mem_req`=1, `mem_*` stable. Requests and input changes ignored. `mem_ready`=1 -> latch `mem_rdata` into owner's rdata (reads only; writes leave `d_rdata` unchanged), err=0, go DONE. Else `wd`+1; when `wd` reaches TIMEOUT-1 without ready -> owner's rdata=0, err=1, go DONE.
- DONE: `mem_req`=0, owner's ack=1 for exactly this cycle, other port's ack=0. Requests not sampled. Next state IDLE unconditionally.
- Requester protocol: requester deasserts req at the edge where it samples ack=1; a req still high in the following IDLE cycle starts a new transaction.
- `mem_ready` in IDLE or DONE is ignored (no state change, no ack).
- err flags and rdata hold their value until the next ack on that port.

## Timing
- Reset: state IDLE, `last_grant`=I (D wins first tie), all outputs 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, acks, errs, rdata, `busy`).
- Reset mid-BUSY: transaction dropped, no ack issued, `mem_req`=0 in cycle after reset edge.
- Latency: req sampled in IDLE cycle n -> `mem_req`=1 from cycle n+1 -> `mem_ready` in cycle n+k (k≥1) -> ack in cycle n+k+1. Minimum 2 cycles request-to-ack.
- Timeout: `mem_ready` never high -> `mem_req` high exactly TIMEOUT cycles, ack+err in next cycle.
- Throughput: one transaction per (memory latency + 2) cycles; IDLE always occupies ≥1 cycle between transactions.
- Fairness: with both reqs continuously high, grants alternate D, I, D, I…; I waits at most one D transaction.

## Test plan
- Reset then idle: rst high 2 cycles -> all outputs 0, `busy`=0; `mem_ready` pulse in IDLE -> no ack.
- Single I read, memory ready 1 cycle after `mem_req`: `i_addr`=0x40, `mem_rdata`=0xDEADBEEF -> `mem_addr`=0x40, `mem_we`=0, `i_ack` 1 cycle with `i_rdata`=0xDEADBEEF, `i_err`=0, total 2 cycles.
- D write, 3-cycle memory: `d_we`=1, `d_addr`=0x100, `d_wdata`=0x12345678 -> `mem_we`=1, `mem_wdata`=0x12345678 held 3 cycles, `d_ack` pulse, `d_rdata` unchanged.
- Contention: both reqs held high across 4 transactions -> grant order D, I, D, I; each ack only on its port.
- Timeout: TIMEOUT=15, no `mem_ready` -> `mem_req` high 15 cycles, then `d_ack`=1, `d_err`=1, `d_rdata`=0; next read with ready clears err.
- Reset mid-BUSY: assert rst in 2nd BUSY cycle -> `mem_req`=0 next cycle, no ack, subsequent request served normally with D-priority restored.
